// File: rtl/disp_rd_sched_pkg.sv
// Shared display-pipeline definitions: frame geometry, bus width and the
// read-scheduler state encoding.
package disp_rd_sched_pkg;

  localparam int DISP_H_ACTIVE   = 640;
  localparam int DISP_V_ACTIVE   = 480;
  localparam int DISP_PIX_BYTES  = 4;
  localparam int DISP_BEAT_BYTES = 8;
  localparam int DISP_FRAME_BEATS =
    DISP_H_ACTIVE * DISP_V_ACTIVE * DISP_PIX_BYTES / DISP_BEAT_BYTES;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_SPACE = 2'd1,
    ST_REQ        = 2'd2,
    ST_DATA       = 2'd3
  } rd_state_e;

endpackage

// File: rtl/disp_rd_sched_space.sv
// Registered free-space check on the line FIFO: high when a full burst fits.
// FIFOCNT above FIFO_DEPTH counts as a full FIFO instead of wrapping.
module disp_rd_space #(
  parameter int FIFO_DEPTH = 1024,
  parameter int BURST_LEN  = 16,
  parameter int CNT_W      = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] fifocnt_i,
  output logic             space_ok_o
);

  localparam int W = CNT_W + 1;
  localparam logic [W-1:0] DEPTH = W'(FIFO_DEPTH);
  localparam logic [W-1:0] BLEN  = W'(BURST_LEN);

  logic [W-1:0] cnt;
  logic [W-1:0] free;
  logic         ok_q;

  always_comb begin
    cnt  = {1'b0, fifocnt_i};
    free = (cnt > DEPTH) ? '0 : (DEPTH - cnt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ok_q <= 1'b0;
    else        ok_q <= (free >= BLEN);
  end

  assign space_ok_o = ok_q;

endmodule

// File: rtl/disp_rd_sched.sv
// Frame-level VRAM read scheduler: walks a frame in fixed aligned bursts,
// one outstanding at a time, gated on line-FIFO free space.
module disp_rd_sched
  import disp_rd_sched_pkg::*;
#(
  parameter int BEAT_BYTES  = DISP_BEAT_BYTES,
  parameter int BURST_LEN   = 16,
  parameter int FRAME_BEATS = DISP_FRAME_BEATS,
  parameter int FIFO_DEPTH  = 1024,
  parameter int CNT_W       = 11
) (
  input  logic             ACLK,
  input  logic             ARSTN,
  input  logic             AXISTART,
  input  logic             DISPON,
  input  logic [31:0]      BASEADR,
  input  logic [CNT_W-1:0] FIFOCNT,
  output logic             RDREQ,
  input  logic             RDACK,
  output logic [31:0]      RDADDR,
  output logic [7:0]       RDLEN,
  input  logic             RDDONE,
  output logic             BUSY,
  output logic             FRMDONE,
  output logic             FRMERR
);

  localparam int NBURST = FRAME_BEATS / BURST_LEN;
  localparam int BSTEP  = BURST_LEN * BEAT_BYTES;
  localparam int BCNT_W = $clog2(NBURST + 1);
  localparam logic [31:0] ALIGN_MASK = ~(32'(BSTEP) - 32'd1);
  localparam logic [BCNT_W-1:0] LAST_BURST = BCNT_W'(NBURST - 1);

  rd_state_e         state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic              rdreq_q, rdreq_d;
  logic              busy_q, busy_d;
  logic              frmdone_q, frmdone_d;
  logic              frmerr_q, frmerr_d;
  logic              space_ok;

  disp_rd_space #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .BURST_LEN  (BURST_LEN),
    .CNT_W      (CNT_W)
  ) u_space (
    .clk        (ACLK),
    .rst_n      (ARSTN),
    .fifocnt_i  (FIFOCNT),
    .space_ok_o (space_ok)
  );

  always_ff @(posedge ACLK or negedge ARSTN) begin
    if (!ARSTN) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      bcnt_q    <= '0;
      rdreq_q   <= 1'b0;
      busy_q    <= 1'b0;
      frmdone_q <= 1'b0;
      frmerr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      bcnt_q    <= bcnt_d;
      rdreq_q   <= rdreq_d;
      busy_q    <= busy_d;
      frmdone_q <= frmdone_d;
      frmerr_q  <= frmerr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    bcnt_d    = bcnt_q;
    rdreq_d   = rdreq_q;
    busy_d    = busy_q;
    frmdone_d = 1'b0;
    // A restart while a frame is running is flagged and dropped, including
    // the cycle of the final RDDONE.
    frmerr_d  = AXISTART && busy_q;
    unique case (state_q)
      ST_IDLE: begin
        if (AXISTART && DISPON) begin
          addr_d  = BASEADR & ALIGN_MASK;
          bcnt_d  = '0;
          busy_d  = 1'b1;
          state_d = ST_WAIT_SPACE;
        end
      end
      ST_WAIT_SPACE: begin
        if (space_ok) begin
          rdreq_d = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (RDACK) begin
          rdreq_d = 1'b0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (RDDONE) begin
          addr_d = addr_q + 32'(BSTEP);
          bcnt_d = bcnt_q + BCNT_W'(1);
          if (bcnt_q == LAST_BURST) begin
            frmdone_d = 1'b1;
            busy_d    = 1'b0;
            state_d   = ST_IDLE;
          end else begin
            state_d = ST_WAIT_SPACE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign RDREQ   = rdreq_q;
  assign RDADDR  = addr_q;
  assign RDLEN   = 8'(BURST_LEN - 1);
  assign BUSY    = busy_q;
  assign FRMDONE = frmdone_q;
  assign FRMERR  = frmerr_q;

endmodule

// File: tb/tb_disp_rd_sched.sv
// Scoreboarded bench for disp_rd_sched: expected burst addresses are queued
// at frame start and popped by a monitor on each RDREQ/RDACK handshake.
module tb_disp_rd_sched;

  logic        ACLK = 1'b0;
  logic        ARSTN;
  logic        AXISTART, DISPON, RDACK, RDDONE;
  logic [31:0] BASEADR;
  logic [10:0] FIFOCNT;
  logic        RDREQ, BUSY, FRMDONE, FRMERR;
  logic [31:0] RDADDR;
  logic [7:0]  RDLEN;

  disp_rd_sched dut (
    .ACLK(ACLK), .ARSTN(ARSTN), .AXISTART(AXISTART), .DISPON(DISPON),
    .BASEADR(BASEADR), .FIFOCNT(FIFOCNT), .RDREQ(RDREQ), .RDACK(RDACK),
    .RDADDR(RDADDR), .RDLEN(RDLEN), .RDDONE(RDDONE), .BUSY(BUSY),
    .FRMDONE(FRMDONE), .FRMERR(FRMERR)
  );

  always #5 ACLK = ~ACLK;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  int          hs = 0;
  int          req_cyc = 0;
  int          req_obs[0:15];
  logic [31:0] last_hs_addr = '0;
  int          frmdone_n = 0;
  int          frmerr_n = 0;
  int          bidx = 0;
  bit          ackd = 0;
  bit          waiting = 0;
  int          wait_c = 0;
  int          done_c = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  // AXI-side responder: burst 2 gets a 7-cycle ack delay, bursts 0..2 finish
  // 16 cycles after ack, later ones finish on the next cycle.
  initial begin
    RDACK = 1'b0;
    RDDONE = 1'b0;
    forever begin
      @(negedge ACLK);
      RDACK = 1'b0;
      RDDONE = 1'b0;
      if (!ARSTN) begin
        ackd = 0; waiting = 0; bidx = 0;
      end else if (ackd) begin
        if (done_c > 1) done_c--;
        else begin RDDONE = 1'b1; ackd = 0; bidx++; end
      end else if (RDREQ) begin
        if (!waiting) begin waiting = 1; wait_c = (bidx == 2) ? 7 : 0; end
        if (wait_c > 0) wait_c--;
        else begin
          RDACK = 1'b1; ackd = 1; waiting = 0;
          done_c = (bidx < 3) ? 16 : 1;
        end
      end
    end
  end

  // Monitor: every RDREQ cycle must present the queued address and ARLEN 15.
  initial begin
    forever begin
      @(negedge ACLK);
      #1;
      if (!ARSTN) req_cyc = 0;
      else begin
        if (RDREQ) begin
          req_cyc++;
          if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_rdreq: got addr %h expected no request", RDADDR);
          end else begin
            chk("rdaddr", RDADDR, exp_q[0]);
            chk("rdlen", 32'(RDLEN), 32'd15);
            if (RDACK) begin
              last_hs_addr = exp_q.pop_front();
              if (hs < 16) req_obs[hs] = req_cyc;
              hs++;
              req_cyc = 0;
            end
          end
        end
        if (FRMDONE) frmdone_n++;
        if (FRMERR) frmerr_n++;
      end
    end
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected test completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    ARSTN = 1'b0; AXISTART = 1'b0; DISPON = 1'b1; BASEADR = '0; FIFOCNT = '0;
    #1;
    chk("rst_rdreq", 32'(RDREQ), 0);
    chk("rst_rdaddr", RDADDR, 0);
    chk("rst_rdlen", 32'(RDLEN), 15);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_frmdone", 32'(FRMDONE), 0);
    chk("rst_frmerr", 32'(FRMERR), 0);
    cyc(3);
    ARSTN = 1'b1;
    cyc(2);

    // Start pulse with display off is ignored
    DISPON = 1'b0; AXISTART = 1'b1; BASEADR = 32'h1000_0040;
    cyc(1);
    AXISTART = 1'b0;
    chk("dispoff_busy", 32'(BUSY), 0);
    chk("dispoff_frmerr", 32'(FRMERR), 0);
    cyc(3);
    chk("dispoff_rdreq", 32'(RDREQ), 0);
    DISPON = 1'b1;

    // Frame 1: full 9600 bursts from an unaligned base
    for (int i = 0; i < 9600; i++) exp_q.push_back(32'h1000_0000 + 32'(i) * 32'd128);
    AXISTART = 1'b1;
    cyc(1);
    AXISTART = 1'b0;
    chk("start_busy", 32'(BUSY), 1);
    chk("start_rdreq_c1", 32'(RDREQ), 0);
    cyc(1);
    chk("start_rdreq_c2", 32'(RDREQ), 1);
    chk("start_rdaddr", RDADDR, 32'h1000_0000);
    chk("start_rdlen", 32'(RDLEN), 15);

    // FIFO space throttle while burst 4 is pending
    wait (bidx == 4);
    FIFOCNT = 11'd1009;
    for (int i = 0; i < 20; i++) begin cyc(1); chk("thr_1009", 32'(RDREQ), 0); end
    FIFOCNT = 11'd1023;
    for (int i = 0; i < 5; i++) begin cyc(1); chk("thr_1023", 32'(RDREQ), 0); end
    FIFOCNT = 11'd2047;
    for (int i = 0; i < 5; i++) begin cyc(1); chk("thr_2047", 32'(RDREQ), 0); end
    FIFOCNT = 11'd1008;
    cyc(1);
    chk("thr_1008_c1", 32'(RDREQ), 0);
    cyc(1);
    chk("thr_1008_c2", 32'(RDREQ), 1);
    chk("thr_1008_addr", RDADDR, 32'h1000_0200);
    FIFOCNT = '0;

    // Restart attempt mid-frame
    wait (bidx == 5);
    cyc(1);
    AXISTART = 1'b1;
    cyc(1);
    AXISTART = 1'b0;
    chk("err_mid_frmerr", 32'(FRMERR), 1);
    chk("err_mid_busy", 32'(BUSY), 1);
    cyc(1);
    chk("err_mid_frmerr_clr", 32'(FRMERR), 0);

    // Restart attempt coinciding with the final RDDONE
    wait (bidx == 9599 && ackd);
    @(negedge ACLK);
    AXISTART = 1'b1;
    @(posedge ACLK);
    #1;
    AXISTART = 1'b0;
    chk("end_frmdone", 32'(FRMDONE), 1);
    chk("end_frmerr", 32'(FRMERR), 1);
    chk("end_busy", 32'(BUSY), 0);
    cyc(1);
    chk("end_frmdone_clr", 32'(FRMDONE), 0);
    chk("end_frmerr_clr", 32'(FRMERR), 0);
    for (int i = 0; i < 5; i++) begin cyc(1); chk("end_idle_rdreq", 32'(RDREQ), 0); end
    chk("frame_bursts", 32'(hs), 9600);
    chk("frame_queue_left", 32'(exp_q.size()), 0);
    chk("frame_last_addr", last_hs_addr, 32'h1012_BF80);
    chk("frame_frmdone_n", 32'(frmdone_n), 1);
    chk("frame_frmerr_n", 32'(frmerr_n), 2);
    chk("ack0_req_cycles", 32'(req_obs[0]), 1);
    chk("ack7_req_cycles", 32'(req_obs[2]), 8);

    // Frame 2: asynchronous reset while burst 2 is in flight
    bidx = 0;
    for (int i = 0; i < 3; i++) exp_q.push_back(32'h3000_0100 + 32'(i) * 32'd128);
    BASEADR = 32'h3000_0100;
    AXISTART = 1'b1;
    cyc(1);
    AXISTART = 1'b0;
    wait (bidx == 2 && ackd);
    @(negedge ACLK);
    #3;
    ARSTN = 1'b0;
    #1;
    chk("arst_rdreq", 32'(RDREQ), 0);
    chk("arst_rdaddr", RDADDR, 0);
    chk("arst_rdlen", 32'(RDLEN), 15);
    chk("arst_busy", 32'(BUSY), 0);
    chk("arst_frmdone", 32'(FRMDONE), 0);
    chk("arst_queue_left", 32'(exp_q.size()), 0);
    cyc(3);
    ARSTN = 1'b1;
    cyc(2);
    chk("arst_idle_busy", 32'(BUSY), 0);

    // Frame 3: fresh start from a new base after reset
    for (int i = 0; i < 3; i++) exp_q.push_back(32'h2000_0080 + 32'(i) * 32'd128);
    BASEADR = 32'h2000_00FF;
    AXISTART = 1'b1;
    cyc(1);
    AXISTART = 1'b0;
    chk("restart_busy", 32'(BUSY), 1);
    cyc(1);
    chk("restart_rdreq", 32'(RDREQ), 1);
    chk("restart_rdaddr", RDADDR, 32'h2000_0080);
    wait (hs == 9606);
    ARSTN = 1'b0;
    #1;
    chk("restart_queue_left", 32'(exp_q.size()), 0);
    chk("restart_frmdone_n", 32'(frmdone_n), 1);
    chk("restart_frmerr_n", 32'(frmerr_n), 2);
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
